// File: rtl/output_action_rr_scheduler.sv
// Round-robin scheduler merging four action producers onto one registered
// single-beat AXI-Stream; words with an empty port bitmap are dropped.
module output_action_rr_scheduler #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACT_TDATA_WIDTH  = 256,
    parameter int C_ACT_TUSER_WIDTH  = 128,
    parameter int NUM_SOURCES        = 4,
    parameter int NUM_QUEUES         = 5
) (
    input  logic                          axi_aclk,
    input  logic                          axi_resetn,
    input  logic [NUM_SOURCES-1:0]        src_enable,

    input  logic [C_ACT_TDATA_WIDTH-1:0]  s_axis_tdata_0,
    input  logic [C_ACT_TUSER_WIDTH-1:0]  s_axis_tuser_0,
    input  logic                          s_axis_tvalid_0,
    output logic                          s_axis_tready_0,

    input  logic [C_ACT_TDATA_WIDTH-1:0]  s_axis_tdata_1,
    input  logic [C_ACT_TUSER_WIDTH-1:0]  s_axis_tuser_1,
    input  logic                          s_axis_tvalid_1,
    output logic                          s_axis_tready_1,

    input  logic [C_ACT_TDATA_WIDTH-1:0]  s_axis_tdata_2,
    input  logic [C_ACT_TUSER_WIDTH-1:0]  s_axis_tuser_2,
    input  logic                          s_axis_tvalid_2,
    output logic                          s_axis_tready_2,

    input  logic [C_ACT_TDATA_WIDTH-1:0]  s_axis_tdata_3,
    input  logic [C_ACT_TUSER_WIDTH-1:0]  s_axis_tuser_3,
    input  logic                          s_axis_tvalid_3,
    output logic                          s_axis_tready_3,

    output logic [C_ACT_TDATA_WIDTH-1:0]  m_axis_tdata,
    output logic [C_ACT_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,

    output logic [C_S_AXI_DATA_WIDTH-1:0] sched_grant_counter,
    output logic [C_S_AXI_DATA_WIDTH-1:0] sched_drop_counter
);

    logic [C_ACT_TDATA_WIDTH-1:0] s_data [NUM_SOURCES];
    logic [C_ACT_TUSER_WIDTH-1:0] s_user [NUM_SOURCES];
    logic [NUM_SOURCES-1:0]       s_valid;
    logic [NUM_SOURCES-1:0]       req;
    logic [NUM_SOURCES-1:0]       grant;
    logic [NUM_SOURCES-1:0]       s_ready;
    logic [1:0]                   rr_ptr;
    logic [1:0]                   grant_idx;
    logic                         load_ok;
    logic                         accept;
    logic                         bitmap_nz;

    assign s_data  = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3};
    assign s_user  = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3};
    assign s_valid = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

    assign req     = s_valid & src_enable;
    assign load_ok = ~m_axis_tvalid | m_axis_tready;

    // First requester at or after rr_ptr, wrapping; one-hot by construction.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant     = '0;
        grant_idx = rr_ptr;
        found     = 1'b0;
        idx       = rr_ptr;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    assign accept    = (|grant) & load_ok;
    assign bitmap_nz = |s_user[grant_idx][NUM_QUEUES-1:0];

    // Ready is also held low while reset is asserted.
    assign s_ready         = grant & {NUM_SOURCES{load_ok & axi_resetn}};
    assign s_axis_tready_0 = s_ready[0];
    assign s_axis_tready_1 = s_ready[1];
    assign s_axis_tready_2 = s_ready[2];
    assign s_axis_tready_3 = s_ready[3];

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            m_axis_tvalid       <= 1'b0;
            m_axis_tdata        <= '0;
            m_axis_tuser        <= '0;
            rr_ptr              <= '0;
            sched_grant_counter <= '0;
            sched_drop_counter  <= '0;
        end else if (accept) begin
            rr_ptr <= grant_idx + 2'd1;
            if (bitmap_nz) begin
                m_axis_tdata        <= s_data[grant_idx];
                m_axis_tuser        <= s_user[grant_idx];
                m_axis_tvalid       <= 1'b1;
                sched_grant_counter <= sched_grant_counter + C_S_AXI_DATA_WIDTH'(1);
            end else begin
                sched_drop_counter <= sched_drop_counter + C_S_AXI_DATA_WIDTH'(1);
                if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_action_rr_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-cycle reference of the round-robin/drop rules.
module tb_output_action_rr_scheduler;

    logic         clk;
    logic         resetn;
    logic [3:0]   en;
    logic [3:0]   vld;
    logic [255:0] tdata [4];
    logic [127:0] tuser [4];
    logic         m_ready;

    logic [3:0]   rdy;
    logic [255:0] m_tdata;
    logic [127:0] m_tuser;
    logic         m_valid;
    logic [31:0]  gcnt;
    logic [31:0]  dcnt;

    logic [3:0]   sm_rdy;
    logic [255:0] sm_tdata;
    logic [127:0] sm_tuser;
    logic         sm_valid;
    logic [3:0]   sm_gcnt;
    logic [3:0]   sm_dcnt;

    int tests = 0;
    int fails = 0;

    int           ptr;
    bit           exp_valid;
    logic [255:0] exp_data;
    logic [127:0] exp_user;
    int unsigned  exp_gcnt;
    int unsigned  exp_dcnt;
    int           glog[$];

    output_action_rr_scheduler dut (
        .axi_aclk(clk), .axi_resetn(resetn), .src_enable(en),
        .s_axis_tdata_0(tdata[0]), .s_axis_tuser_0(tuser[0]), .s_axis_tvalid_0(vld[0]), .s_axis_tready_0(rdy[0]),
        .s_axis_tdata_1(tdata[1]), .s_axis_tuser_1(tuser[1]), .s_axis_tvalid_1(vld[1]), .s_axis_tready_1(rdy[1]),
        .s_axis_tdata_2(tdata[2]), .s_axis_tuser_2(tuser[2]), .s_axis_tvalid_2(vld[2]), .s_axis_tready_2(rdy[2]),
        .s_axis_tdata_3(tdata[3]), .s_axis_tuser_3(tuser[3]), .s_axis_tvalid_3(vld[3]), .s_axis_tready_3(rdy[3]),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
        .sched_grant_counter(gcnt), .sched_drop_counter(dcnt)
    );

    // Narrow-counter copy so counter wrap is reachable in a few cycles.
    output_action_rr_scheduler #(.C_S_AXI_DATA_WIDTH(4)) dut_small (
        .axi_aclk(clk), .axi_resetn(resetn), .src_enable(en),
        .s_axis_tdata_0(tdata[0]), .s_axis_tuser_0(tuser[0]), .s_axis_tvalid_0(vld[0]), .s_axis_tready_0(sm_rdy[0]),
        .s_axis_tdata_1(tdata[1]), .s_axis_tuser_1(tuser[1]), .s_axis_tvalid_1(vld[1]), .s_axis_tready_1(sm_rdy[1]),
        .s_axis_tdata_2(tdata[2]), .s_axis_tuser_2(tuser[2]), .s_axis_tvalid_2(vld[2]), .s_axis_tready_2(sm_rdy[2]),
        .s_axis_tdata_3(tdata[3]), .s_axis_tuser_3(tuser[3]), .s_axis_tvalid_3(vld[3]), .s_axis_tready_3(sm_rdy[3]),
        .m_axis_tdata(sm_tdata), .m_axis_tuser(sm_tuser), .m_axis_tvalid(sm_valid), .m_axis_tready(m_ready),
        .sched_grant_counter(sm_gcnt), .sched_drop_counter(sm_dcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_src(input int k, input bit v, input logic [4:0] bitmap);
        vld[k]   = v;
        tdata[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tuser[k] = {$urandom, $urandom, $urandom, $urandom};
        tuser[k][4:0] = bitmap;
    endtask

    task automatic model_reset();
        ptr       = 0;
        exp_valid = 0;
        exp_data  = '0;
        exp_user  = '0;
        exp_gcnt  = 0;
        exp_dcnt  = 0;
        glog.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        vld    = 4'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // One clock of traffic: inputs are set just after a negedge; compare, advance model.
    task automatic cycle(input string tag);
        int         g;
        int         k;
        bit         load_ok;
        logic [3:0] exp_rdy;
        #1;
        load_ok = !exp_valid || m_ready;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            k = (ptr + i) % 4;
            if (g < 0 && vld[k] && en[k]) g = k;
        end
        exp_rdy = (g >= 0 && load_ok) ? 4'(1 << g) : 4'b0;

        tests++;
        if (rdy !== exp_rdy) begin
            fails++;
            $display("[TB] FAIL %s ready: got %b expected %b", tag, rdy, exp_rdy);
        end
        tests++;
        if (m_valid !== exp_valid) begin
            fails++;
            $display("[TB] FAIL %s m_valid: got %b expected %b", tag, m_valid, exp_valid);
        end
        if (exp_valid) begin
            tests++;
            if (m_tdata !== exp_data || m_tuser !== exp_user || sm_tdata !== exp_data || sm_tuser !== exp_user) begin
                fails++;
                $display("[TB] FAIL %s out word: got tuser %h expected %h", tag, m_tuser[31:0], exp_user[31:0]);
            end
        end
        tests++;
        if (gcnt !== exp_gcnt || dcnt !== exp_dcnt) begin
            fails++;
            $display("[TB] FAIL %s counters: got g=%0d d=%0d expected g=%0d d=%0d", tag, gcnt, dcnt, exp_gcnt, exp_dcnt);
        end
        tests++;
        if (sm_rdy !== exp_rdy || sm_valid !== exp_valid || sm_gcnt !== 4'(exp_gcnt % 16) || sm_dcnt !== 4'(exp_dcnt % 16)) begin
            fails++;
            $display("[TB] FAIL %s narrow dut: got g=%0d d=%0d expected g=%0d d=%0d", tag, sm_gcnt, sm_dcnt, exp_gcnt % 16, exp_dcnt % 16);
        end

        if (exp_rdy != 4'b0) begin
            glog.push_back(g);
            ptr = (g + 1) % 4;
            if (tuser[g][4:0] != 5'b0) begin
                exp_valid = 1;
                exp_data  = tdata[g];
                exp_user  = tuser[g];
                exp_gcnt++;
            end else begin
                exp_dcnt++;
                if (m_ready) exp_valid = 0;
            end
        end else if (m_ready) begin
            exp_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_log(input string tag, input int exp_seq[$]);
        tests++;
        if (glog != exp_seq) begin
            fails++;
            $display("[TB] FAIL %s grant order: got %p expected %p", tag, glog, exp_seq);
        end
    endtask

    task automatic test_reset();
        en      = 4'hF;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'h01);
        resetn = 1'b0;
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || m_tdata !== '0 || m_tuser !== '0 || gcnt !== 0 || dcnt !== 0 || rdy !== 4'b0) begin
            fails++;
            $display("[TB] FAIL reset: got valid=%b g=%0d d=%0d rdy=%b expected 0", m_valid, gcnt, dcnt, rdy);
        end
        resetn = 1'b1;
        model_reset();
        vld = 4'b0;
    endtask

    task automatic test_fairness();
        do_reset();
        en = 4'hF;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'(1 << k));
            cycle("fairness");
        end
        check_log("fairness", '{0, 1, 2, 3, 0, 1, 2, 3});
        tests++;
        if (gcnt !== 32'd8) begin
            fails++;
            $display("[TB] FAIL fairness grant count: got %0d expected 8", gcnt);
        end
    endtask

    task automatic test_stall();
        logic [255:0] held;
        do_reset();
        vld = 4'b0;
        en = 4'hF;
        m_ready = 1'b1;
        set_src(2, 1'b1, 5'h04);
        cycle("stall first");
        m_ready = 1'b0;
        set_src(2, 1'b1, 5'h04);
        held = exp_data;
        for (int c = 0; c < 5; c++) begin
            cycle("stall hold");
            tests++;
            if (m_tdata !== held || rdy[2] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall hold: got rdy2=%b data_lo=%h expected rdy2=0 data_lo=%h", rdy[2], m_tdata[31:0], held[31:0]);
            end
        end
        m_ready = 1'b1;
        cycle("stall release");
        set_src(2, 1'b1, 5'h04);
        cycle("stall b2b");
        vld = 4'b0;
        cycle("stall drain");
        tests++;
        if (gcnt !== 32'd3) begin
            fails++;
            $display("[TB] FAIL stall word count: got %0d expected 3", gcnt);
        end
    endtask

    task automatic test_drop();
        do_reset();
        en = 4'hF;
        m_ready = 1'b1;
        set_src(1, 1'b1, 5'h00);
        set_src(3, 1'b1, 5'h10);
        cycle("drop src1");
        vld[1] = 1'b0;
        cycle("drop src3");
        vld = 4'b0;
        tests++;
        if (m_valid !== 1'b1 || m_tuser[4:0] !== 5'h10 || dcnt !== 32'd1 || gcnt !== 32'd1) begin
            fails++;
            $display("[TB] FAIL drop result: got bitmap=%h g=%0d d=%0d expected 10 1 1", m_tuser[4:0], gcnt, dcnt);
        end
        cycle("drop drain");
        for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'h01);
        cycle("drop ptr");
        check_log("drop", '{1, 3, 0});
    endtask

    task automatic test_enable_mask();
        do_reset();
        en = 4'b1011;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'(1 << k));
            cycle("enable mask");
        end
        check_log("enable mask", '{0, 1, 3, 0, 1, 3});
        en = 4'hF;
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 4'hF;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'h03);
            cycle("async pre");
        end
        #2 resetn = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || gcnt !== 0 || dcnt !== 0 || rdy !== 4'b0) begin
            fails++;
            $display("[TB] FAIL async reset: got valid=%b g=%0d rdy=%b expected 0", m_valid, gcnt, rdy);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 4; k++) set_src(k, 1'b1, 5'h03);
            cycle("async post");
        end
        check_log("async restart", '{0, 1});
    endtask

    task automatic test_counter_wrap();
        do_reset();
        en = 4'hF;
        m_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            set_src(0, 1'b1, 5'h01);
            cycle("wrap");
            if (c == 15) begin
                tests++;
                if (sm_gcnt !== 4'd0) begin
                    fails++;
                    $display("[TB] FAIL counter wrap: got %0d expected 0", sm_gcnt);
                end
            end
        end
        vld = 4'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            m_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++)
                set_src(k, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom));
            cycle("random");
        end
    endtask

    initial begin
        resetn  = 1'b0;
        vld     = 4'b0;
        en      = 4'hF;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_src(k, 1'b0, 5'h00);
        model_reset();
        @(negedge clk);
        test_reset();
        test_fairness();
        test_stall();
        test_drop();
        test_enable_mask();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_action_rr_scheduler.md
Name: output_action_rr_scheduler

Overview:
- Round-robin scheduler that shares the single action path into the output action arbiter among NUM_SOURCES action producers (lookup tables, controller injection path).
- Each action word is one beat; tuser[NUM_QUEUES-1:0] is the destination port bitmap.
- Output is a registered single-beat AXI-Stream feeding the arbiter's s_axis.
- Words with an all-zero port bitmap are consumed and dropped, not forwarded.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of the statistics counters.
- C_ACT_TDATA_WIDTH, 256, action tdata width (inputs and output).
- C_ACT_TUSER_WIDTH, 128, action tuser width (inputs and output).
- NUM_SOURCES, 4, number of requesters (fixed port set 0..3; must be 4).
- NUM_QUEUES, 5, width of the port bitmap in tuser LSBs.

Ports:
- axi_aclk  in  1  clock.
- axi_resetn  in  1  reset, asynchronous, active-low.
- src_enable  in  NUM_SOURCES  per-source enable from the register block; 0 masks that source's request.
- s_axis_tdata_k  in  C_ACT_TDATA_WIDTH  source k action data (k=0..3).
- s_axis_tuser_k  in  C_ACT_TUSER_WIDTH  source k action tuser; [NUM_QUEUES-1:0] is the port bitmap.
- s_axis_tvalid_k  in  1  source k valid.
- s_axis_tready_k  out  1  source k ready.
- m_axis_tdata  out  C_ACT_TDATA_WIDTH  merged action data.
- m_axis_tuser  out  C_ACT_TUSER_WIDTH  merged action tuser.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- sched_grant_counter  out  C_S_AXI_DATA_WIDTH  count of words forwarded.
- sched_drop_counter  out  C_S_AXI_DATA_WIDTH  count of zero-bitmap words dropped.

Behaviour:

Reset (asynchronous assert, synchronous-safe release):
- m_axis_tvalid=0; m_axis_tdata/tuser=0; rr_ptr=0; both counters=0.
- All s_axis_tready_k are 0 while reset is asserted.
- Reset mid-transfer discards the held output word; no partial state survives.

Request and grant:
- req_k = s_axis_tvalid_k & src_enable[k].
- load_ok = ~m_axis_tvalid | m_axis_tready.
- Grant is combinational and one-hot: the first req_k found searching k = rr_ptr, rr_ptr+1, ... mod 4.
- s_axis_tready_k = grant_k & load_ok. Only the granted source sees ready; there is no ready without a request.
- Accept occurs when s_axis_tvalid_k & s_axis_tready_k.

On accept of source k:
- rr_ptr <= (k+1) mod 4.
- If tuser[NUM_QUEUES-1:0] != 0: output register loads tdata/tuser and m_axis_tvalid <= 1 next cycle. Latency is 1 cycle, accept to m_axis_tvalid. sched_grant_counter increments.
- If the bitmap is 0: word is dropped, output register is not loaded, sched_drop_counter increments.
  - If the output register was draining this cycle (m_axis_tready high), m_axis_tvalid <= 0.
  - A drop still advances rr_ptr.

Output handshake:
- m_axis_tready=1 with no accept: m_axis_tvalid <= 0.
- Simultaneous drain and accept: the new word replaces the old one and m_axis_tvalid stays 1. Throughput is 1 word/cycle.
- m_axis_tvalid high with m_axis_tready low: data/tuser are held stable; no source receives ready.
- m_axis_tvalid never drops without a handshake.

Fairness and boundaries:
- Fairness: with all 4 requesting continuously, grant order is 0,1,2,3,0...
- A source with valid held sees ready within 4 accepts.
- rr_ptr does not move when no accept occurs, including stalled cycles.
- src_enable deasserted while a source is valid but ungranted: that source is ignored. Protocol violation (valid withdrawn) is the source's issue; the scheduler does not latch requests.
- src_enable change takes effect the same cycle (combinational mask).
- Counters wrap modulo 2^C_S_AXI_DATA_WIDTH and never saturate.
- Grant and drop counters never increment in the same cycle.

Test Plan:
1. All 4 sources valid continuously, bitmaps 0x01/0x02/0x04/0x08, m_axis_tready=1 -> output tuser bitmap sequence 01,02,04,08,01,... one word/cycle; first m_axis_tvalid one cycle after first accept; grant counter=8 after 8 cycles.
2. Source 2 only, m_axis_tready held 0 for 5 cycles after first word -> m_axis_tdata stable, s_axis_tready_2=0 during stall; on release next word follows back-to-back; no word lost or duplicated.
3. Source 1 sends bitmap 0x00, source 3 sends 0x10 in consecutive grants -> drop counter=1, grant counter=1, only source 3's word appears at output; rr_ptr after the sequence=0.
4. src_enable=4'b1011 with all valid -> grant order 0,1,3,0,1,3; s_axis_tready_2 never asserts.
5. Assert axi_resetn=0 asynchronously mid-stream with m_axis_tvalid=1 -> m_axis_tvalid and counters 0 immediately (before next clock edge); after release, grant restarts at source 0.
6. Preload grant counter near wrap (0xFFFFFFFF via 2^32-1 accepts in a forced-state test) and accept one word -> counter reads 0x00000000.
